// File: rtl/seg7_mux_driver_pkg.sv
// rtl/seg7_mux_driver_pkg.sv - shared types and constants for the multiplexed 7-segment driver
`include "scoreboard_defs.vh"

package seg7_mux_driver_pkg;

  typedef enum logic [1:0] {
    ST_BLANK_T = 2'd0,
    ST_SHOW_T  = 2'd1,
    ST_BLANK_O = 2'd2,
    ST_SHOW_O  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_OFF = `DIGIT_OFF;
  localparam logic [3:0] DIGIT_P   = `DIGIT_P;

  localparam logic [6:0] SEG_0     = `SEG_0;
  localparam logic [6:0] SEG_1     = `SEG_1;
  localparam logic [6:0] SEG_2     = `SEG_2;
  localparam logic [6:0] SEG_3     = `SEG_3;
  localparam logic [6:0] SEG_4     = `SEG_4;
  localparam logic [6:0] SEG_5     = `SEG_5;
  localparam logic [6:0] SEG_6     = `SEG_6;
  localparam logic [6:0] SEG_7     = `SEG_7;
  localparam logic [6:0] SEG_8     = `SEG_8;
  localparam logic [6:0] SEG_9     = `SEG_9;
  localparam logic [6:0] SEG_P     = `SEG_P;
  localparam logic [6:0] SEG_BLANK = `SEG_BLANK;

  function automatic logic code_is_illegal(input logic [3:0] code);
    return code > DIGIT_P;
  endfunction

endpackage

// File: rtl/scoreboard_defs.vh
// rtl/scoreboard_defs.vh - digit codes and segment patterns shared with the display controller
`ifndef SCOREBOARD_DEFS_VH
`define SCOREBOARD_DEFS_VH

`define DIGIT_OFF 4'd10
`define DIGIT_P   4'd11

// Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
`define SEG_0     7'h3F
`define SEG_1     7'h06
`define SEG_2     7'h5B
`define SEG_3     7'h4F
`define SEG_4     7'h66
`define SEG_5     7'h6D
`define SEG_6     7'h7D
`define SEG_7     7'h07
`define SEG_8     7'h7F
`define SEG_9     7'h6F
`define SEG_P     7'h73
`define SEG_BLANK 7'h00

`endif

// File: rtl/seg7_mux_driver_decoder.sv
// rtl/seg7_mux_driver_decoder.sv - combinational digit code to active-high segment pattern
module seg7_decoder
  import seg7_mux_driver_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o,
  output logic       illegal_o
);

  always_comb begin
    seg_o     = SEG_BLANK;
    illegal_o = code_is_illegal(code_i);
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      DIGIT_P: seg_o = SEG_P;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - frame-latched two-digit 7-segment multiplexer with dead-time blanking
module seg7_mux_driver
  import seg7_mux_driver_pkg::*;
#(
  parameter int SLOT_CYCLES  = 8,
  parameter int BLANK_CYCLES = 1,
  parameter int COMMON_ANODE = 0
) (
  input  logic       clk_1khz,
  input  logic       rst_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  input  logic       lz_blank_i,
  output logic [6:0] seg_o,
  output logic [1:0] dig_o,
  output logic       frame_o,
  output logic       err_o
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);

  generate
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 1) begin : g_bad_blank
      $error("seg7_mux_driver: BLANK_CYCLES must be in 1..SLOT_CYCLES-1");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          lz_q, lz_d;
  logic          frame_q, frame_d;
  logic          err_q, err_d;

  logic          latch;
  logic [3:0]    dec_code;
  logic [6:0]    dec_seg;
  logic          dec_illegal;
  logic [6:0]    seg_act;
  logic [1:0]    dig_act;

  always_ff @(posedge clk_1khz or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_BLANK_T;
      cnt_q   <= '0;
      tens_q  <= DIGIT_OFF;
      ones_q  <= DIGIT_OFF;
      lz_q    <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      lz_q    <= lz_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    latch   = 1'b0;
    case (state_q)
      ST_BLANK_T: if (cnt_q == BLANK_LAST) begin state_d = ST_SHOW_T;  cnt_d = '0; end
      ST_SHOW_T:  if (cnt_q == SHOW_LAST)  begin state_d = ST_BLANK_O; cnt_d = '0; end
      ST_BLANK_O: if (cnt_q == BLANK_LAST) begin state_d = ST_SHOW_O;  cnt_d = '0; end
      ST_SHOW_O:  if (cnt_q == SHOW_LAST) begin
        state_d = ST_BLANK_T;
        cnt_d   = '0;
        latch   = 1'b1;
      end
      default:    begin state_d = ST_BLANK_T; cnt_d = '0; end
    endcase
  end

  // Shadow registers only move at the frame boundary so a digit never tears mid-frame.
  always_comb begin
    tens_d  = tens_q;
    ones_d  = ones_q;
    lz_d    = lz_q;
    err_d   = err_q;
    frame_d = latch;
    if (latch) begin
      tens_d = tens_i;
      ones_d = ones_i;
      lz_d   = lz_blank_i;
      err_d  = err_q | code_is_illegal(tens_i) | code_is_illegal(ones_i);
    end
  end

  assign dec_code = (state_q == ST_SHOW_O) ? ones_q : tens_q;

  seg7_decoder u_decoder (
    .code_i    (dec_code),
    .seg_o     (dec_seg),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    seg_act = SEG_BLANK;
    dig_act = 2'b00;
    case (state_q)
      ST_SHOW_T: begin
        dig_act = 2'b10;
        if (!(lz_q && tens_q == 4'd0) && !dec_illegal) seg_act = dec_seg;
      end
      ST_SHOW_O: begin
        dig_act = 2'b01;
        if (!dec_illegal) seg_act = dec_seg;
      end
      default: begin
        seg_act = SEG_BLANK;
        dig_act = 2'b00;
      end
    endcase
  end

  assign seg_o   = (COMMON_ANODE != 0) ? ~seg_act : seg_act;
  assign dig_o   = (COMMON_ANODE != 0) ? ~dig_act : dig_act;
  assign frame_o = frame_q;
  assign err_o   = err_q;

endmodule
